shift_sequencer: RTL
====================

// Module: shift_sequencer
// PURPOSE
//   Multi-cycle shift engine built around the 1-bit logical shift step.
//   - Accepts an operand, a direction and a shift amount over a valid/ready handshake.
//   - Applies one single-position shift per clock, iterating for the requested amount.
//   - Presents the result on a valid/ready output held stable until consumed.
//   - Sits directly upstream of the result consumer; feeds the shift step each cycle.
// PARAMETERS
//   WIDTH  4  operand/result width in bits (>=2)
//   AMT_W  3  width of shift-amount input; amounts >= WIDTH saturate to WIDTH
// PORTS
//   clk        in   1      single clock; all state on rising edge
//   rst        in   1      asynchronous, active-high reset
//   in_valid   in   1      request valid
//   in_ready   out  1      sequencer can accept (high only in IDLE)
//   in_data    in   WIDTH  operand
//   in_dir     in   1      0 = left shift, 1 = right shift (zero fill)
//   in_amt     in   AMT_W  number of positions to shift
//   out_valid  out  1      result valid (DONE state)
//   out_ready  in   1      consumer accepts result
//   out_data   out  WIDTH  shifted result
//   busy       out  1      high in SHIFT or DONE
// BEHAVIOUR
//   - Reset: state=IDLE; in_ready=1; out_valid=0; busy=0; out_data=0; internal count=0.
//   - FSM states:
//     - IDLE: on in_valid&&in_ready, latch data and dir; count <= min(in_amt, WIDTH).
//       Next state: SHIFT if count>0, else DONE.
//     - SHIFT: each cycle data <= step(data,dir), count <= count-1.
//       At count==1 the final shift is applied and next state is DONE.
//     - DONE: out_valid=1; out_data=data, stable.
//       On out_valid&&out_ready the next state is IDLE.
//       No new request is accepted in the same cycle.
//   - Latency: request accepted in cycle t -> out_valid first high in cycle t+1+min(amt,WIDTH).
//   - Shift boundaries:
//     - Left shift: bit 0 filled with 0.
//     - Right shift: MSB filled with 0.
//     - amt >= WIDTH yields all zeros.
//   - Input side: in_data/in_dir/in_amt are sampled only on the accept cycle.
//     Changes during SHIFT/DONE are ignored.
//   - Output backpressure: out_ready low in DONE holds out_valid and out_data indefinitely.
//   - out_ready while not in DONE has no effect.
//   - Reset asserted mid-operation: immediate return to reset values; the in-flight result is discarded.
// CONFIGURATION
//   SHIFT_SEQ_ROTATE_EN
//     - Defined: adds input port in_rot (1 bit), latched on accept.
//       in_rot=1 makes each step a rotate: the vacated bit takes the bit shifted out.
//       Saturation still applies (amt >= WIDTH clamps to WIDTH).
//       A rotate by WIDTH therefore returns the original operand.
//     - Undefined: no in_rot port; logical shift only.
// STRUCTURE
//   - Shared package shift_seq_pkg:
//     - state encodings ST_IDLE=2'd0, ST_SHIFT=2'd1, ST_DONE=2'd2
//     - DIR_LEFT=1'b0, DIR_RIGHT=1'b1
//   - Sub-module shift_step (combinational, WIDTH-parameterised):
//     - Inputs: a, dir (plus rot when SHIFT_SEQ_ROTATE_EN is defined); output y.
//     - Instantiated once on the data register.
//   - Top level holds only the FSM, count and data registers.
// TESTING
//   1. Reset: assert rst -> in_ready=1, out_valid=0, busy=0, out_data=0000.
//   2. data=1101, dir=0, amt=1 accepted at t -> out_data=1010, out_valid rises at t+2.
//   3. data=1101, dir=1, amt=2 -> out_data=0011 at t+3.
//      Then data=0011, dir=1, amt=0 -> out_data=0011 at t+1.
//   4. data=1111, dir=0, amt=7 -> saturates; out_data=0000 at t+5 (not t+8).
//   5. Backpressure: hold out_ready=0 for 6 cycles in DONE -> out_valid and out_data stable, in_ready=0.
//      Then out_ready=1 for 1 cycle -> IDLE next cycle; in_ready=1.
//   6. Reset mid-operation: assert rst in the 2nd SHIFT cycle of a 4-position shift -> outputs at reset values.
//      Next request completes normally.
//      With SHIFT_SEQ_ROTATE_EN: data=1001, dir=0, rot=1, amt=1 -> 0011.

Source files
------------

// File: rtl/shift_seq_pkg.sv
// Shared definitions for the shift sequencer: FSM state encodings, shift
// direction codes and the shift-amount saturation helper.
package shift_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    // Shifting by the full width or more always empties the operand (or, when
    // rotating, brings it back), so the iteration count never exceeds width.
    function automatic int unsigned sat_amt(input int unsigned amt, input int unsigned width);
        return (amt >= width) ? width : amt;
    endfunction

endpackage

// File: rtl/shift_sequencer_shift_step.sv
// Single-position shift step, purely combinational.
// Left shift fills bit 0, right shift fills the MSB. The fill is zero unless
// SHIFT_SEQ_ROTATE_EN is defined and rot is high, in which case the bit that
// falls off the other end is wrapped around.
module shift_step
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic             dir,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic             rot,
`endif
    output logic [WIDTH-1:0] y
);

    logic fill_l;
    logic fill_r;

`ifdef SHIFT_SEQ_ROTATE_EN
    assign fill_l = rot & a[WIDTH-1];
    assign fill_r = rot & a[0];
`else
    assign fill_l = 1'b0;
    assign fill_r = 1'b0;
`endif

    // Move every bit one position in the requested direction.
    always_comb begin
        y = a;
        if (dir == DIR_LEFT) begin
            y = {a[WIDTH-2:0], fill_l};
        end else begin
            y = {fill_r, a[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/shift_sequencer.sv
// Multi-cycle shift engine: accepts an operand over a valid/ready handshake,
// applies one single-position shift per clock for min(amt, WIDTH) clocks, then
// holds the result on a valid/ready output until consumed.
// Optional feature macro: SHIFT_SEQ_ROTATE_EN adds the in_rot port (rotate
// instead of logical shift, latched on accept).
module shift_sequencer
    import shift_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_dir,
    input  logic [AMT_W-1:0] in_amt,
`ifdef SHIFT_SEQ_ROTATE_EN
    input  logic             in_rot,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] data_q, data_d;
    logic             dir_q, dir_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] step_y;
`ifdef SHIFT_SEQ_ROTATE_EN
    logic             rot_q, rot_d;
`endif

    shift_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .a   (data_q),
        .dir (dir_q),
`ifdef SHIFT_SEQ_ROTATE_EN
        .rot (rot_q),
`endif
        .y   (step_y)
    );

    assign in_ready  = (state_q == ST_IDLE);
    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q == ST_SHIFT) || (state_q == ST_DONE);
    assign out_data  = data_q;

    // Next-state logic: latch the request in IDLE, step the data in SHIFT,
    // wait for the consumer in DONE.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        dir_d   = dir_q;
        count_d = count_q;
`ifdef SHIFT_SEQ_ROTATE_EN
        rot_d   = rot_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    data_d  = in_data;
                    dir_d   = in_dir;
                    count_d = CNT_W'(sat_amt(32'(in_amt), WIDTH));
`ifdef SHIFT_SEQ_ROTATE_EN
                    rot_d   = in_rot;
`endif
                    state_d = (count_d != '0) ? ST_SHIFT : ST_DONE;
                end
            end
            ST_SHIFT: begin
                data_d  = step_y;
                count_d = count_q - CNT_W'(1);
                if (count_q == CNT_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // A new request cannot be taken in the release cycle because
                // in_ready is only high in IDLE.
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand and iteration-count registers; reset drops any in-flight result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            dir_q   <= DIR_LEFT;
            count_q <= '0;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            dir_q   <= dir_d;
            count_q <= count_d;
`ifdef SHIFT_SEQ_ROTATE_EN
            rot_q   <= rot_d;
`endif
        end
    end

endmodule
